zero_mem_arbiter: RTL and testbench
===================================

// Module: zero_mem_arbiter
// PURPOSE
//  Shares the single core RAM port between instruction fetch (IF) and the data/MEM stage.
//  Sequences each access with a small FSM: grant -> RAM command -> fixed-latency wait -> response.
//  MEM wins ties (older instruction); a streak limit guarantees IF forward progress.
//  Sits between the pipeline stages and the RamRead*/RamWrite* interface of the core.
// PARAMETERS
//  ADDR_W     64  address width (ADDR_BUS)
//  DATA_W     64  RAM data/mask width (DATA_BUS)
//  RAM_LAT    1   cycles from ram_ren to valid ram_rdata; legal 1..4
//  MEM_STREAK 4   max consecutive MEM grants while if_req is pending; legal 1..15
// PORTS
//  clk        in   1       core clock, all logic on rising edge
//  rst        in   1       synchronous, active-low reset
//  if_req     in   1       IF read request, held until if_gnt
//  if_addr    in   ADDR_W  IF fetch address; bits[1:0] ignored
//  if_gnt     out  1       IF request accepted this cycle
//  if_rvalid  out  1       IF response valid (one-cycle pulse)
//  if_rdata   out  32      fetched instruction
//  mem_req    in   1       MEM request, held until mem_gnt
//  mem_we     in   1       1 = write, 0 = read
//  mem_addr   in   ADDR_W  MEM address, passed through unchecked
//  mem_wdata  in   DATA_W  write data
//  mem_wmask  in   DATA_W  per-bit write mask
//  mem_gnt    out  1       MEM request accepted this cycle
//  mem_done   out  1       MEM access complete (one-cycle pulse); rdata valid if read
//  mem_rdata  out  DATA_W  read data
//  ram_ren    out  1       RAM read enable
//  ram_wen    out  1       RAM write enable
//  ram_raddr  out  ADDR_W  RAM read address
//  ram_waddr  out  ADDR_W  RAM write address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_wmask  out  DATA_W  RAM write mask
//  ram_rdata  in   DATA_W  RAM read data
// BEHAVIOUR
//  - States: IDLE, BUSY_IF, BUSY_MEM. rst=0 at an edge -> IDLE, cnt=0, streak=0, owner cleared.
//  - Every output is 0 while rst=0 and whenever not explicitly driven below (no X, no stale data).
//  - IDLE arbitration, cycle T, combinational:
//      mem_req & (!if_req | streak<MEM_STREAK) -> MEM wins; else if_req -> IF wins; else stay IDLE.
//  - Grant cycle T: winner's gnt=1; RAM command issued the same cycle, one-cycle pulse:
//      IF read: ram_ren=1, ram_raddr=if_addr; latch if_addr[2].
//      MEM read: ram_ren=1, ram_raddr=mem_addr. MEM write: ram_wen=1, ram_waddr/wdata/wmask from mem_*; ram_ren=0.
//      cnt<=1; state<=BUSY_IF or BUSY_MEM.
//  - BUSY read: ram_* = 0. When cnt==RAM_LAT: rvalid/done=1, data taken combinationally from ram_rdata;
//      state<=IDLE. Otherwise cnt<=cnt+1.
//      if_rdata = latched addr[2] ? ram_rdata[63:32] : ram_rdata[31:0].
//  - BUSY_MEM write: mem_done=1 at T+1 regardless of RAM_LAT; state<=IDLE.
//  - No grant in BUSY or in the response cycle. Read issue rate is one per RAM_LAT+1 cycles;
//      write issue rate is one per 2 cycles.
//  - Streak counter, saturating 4-bit:
//      MEM grant with if_req=1 -> streak+1; MEM grant with if_req=0 -> 0; IF grant -> 0.
//  - Requests dropped before gnt are allowed and simply not served.
//      Inputs are sampled only in the IDLE grant cycle; later changes are ignored.
//  - Reset mid-operation: the outstanding access is abandoned and no rvalid/done is emitted for it.
//      The next request after reset is granted normally.
// TESTING
//  1 Reset: rst=0 for 2 cycles with if_req=mem_req=1 -> no gnt; ram_ren=ram_wen=0; all outputs 0.
//  2 IF read, RAM_LAT=1: if_req, if_addr=0x80000004 at T -> if_gnt@T, ram_ren@T, ram_raddr=0x80000004;
//    if_rvalid@T+1 with if_rdata=ram_rdata[63:32].
//  3 Both requesting continuously, MEM_STREAK=4 -> grant order M,M,M,M,I,M,M,M,M,I.
//    Drop if_req after the first M grant -> streak clears and all grants go to M.
//  4 MEM write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xFFFFFFFF -> ram_wen@T with those values,
//    ram_ren=0@T; mem_done@T+1; next grant possible @T+2.
//  5 RAM_LAT=3: MEM read granted @T, rst=0 @T+1 -> no mem_done @T+3; FSM in IDLE.
//    if_req @T+4 -> if_gnt @T+4.
//  6 RAM_LAT=2, if_req held high throughout -> if_gnt @T, T+3, T+6; if_rvalid @T+2, T+5, T+8.

Source files
------------

// File: rtl/zero_mem_arbiter.sv
// Arbitrates the single core RAM port between instruction fetch and the MEM stage.
// Each access runs grant -> RAM command -> fixed-latency wait -> response; MEM wins ties up to a streak limit.
module zero_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int RAM_LAT    = 1,
    parameter int MEM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_wmask,
    output logic              mem_gnt,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester holds req until it sees gnt in the same cycle; the
    // matching rvalid/done is a single-cycle pulse, with data valid only in that cycle.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;

    logic [1:0] state;
    logic [2:0] cnt;
    logic [3:0] streak;
    logic       mem_wr_q;
    logic       if_hi_q;

    logic idle;
    logic mem_win;
    logic if_win;
    logic mem_rd_win;
    logic last;
    logic if_resp;
    logic mem_resp;

    assign idle       = rst && (state == IDLE);
    assign mem_win    = idle && mem_req && (!if_req || (streak < 4'(MEM_STREAK)));
    assign if_win     = idle && if_req && !mem_win;
    assign mem_rd_win = mem_win && !mem_we;
    assign last       = (cnt == 3'(RAM_LAT));
    assign if_resp    = rst && (state == BUSY_IF) && last;
    // Writes complete one cycle after the command no matter how slow reads are.
    assign mem_resp   = rst && (state == BUSY_MEM) && (mem_wr_q || last);

    assign if_gnt    = if_win;
    assign mem_gnt   = mem_win;
    assign ram_ren   = if_win || mem_rd_win;
    assign ram_wen   = mem_win && mem_we;
    assign ram_raddr = if_win ? if_addr : (mem_rd_win ? mem_addr : '0);
    assign ram_waddr = ram_wen ? mem_addr  : '0;
    assign ram_wdata = ram_wen ? mem_wdata : '0;
    assign ram_wmask = ram_wen ? mem_wmask : '0;

    assign if_rvalid = if_resp;
    assign if_rdata  = !if_resp ? 32'd0 : (if_hi_q ? ram_rdata[63:32] : ram_rdata[31:0]);
    assign mem_done  = mem_resp;
    assign mem_rdata = (mem_resp && !mem_wr_q) ? ram_rdata : '0;
    assign fsm_state = rst ? state : IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            streak   <= 4'd0;
            mem_wr_q <= 1'b0;
            if_hi_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_win) begin
                        state    <= BUSY_MEM;
                        cnt      <= 3'd1;
                        mem_wr_q <= mem_we;
                        // Count only grants that actually made a fetch wait.
                        if (if_req)
                            streak <= (streak == 4'hF) ? streak : streak + 4'd1;
                        else
                            streak <= 4'd0;
                    end else if (if_win) begin
                        state   <= BUSY_IF;
                        cnt     <= 3'd1;
                        if_hi_q <= if_addr[2];
                        streak  <= 4'd0;
                    end
                end
                BUSY_IF: begin
                    if (last) state <= IDLE;
                    else      cnt   <= cnt + 3'd1;
                end
                BUSY_MEM: begin
                    if (mem_wr_q || last) state <= IDLE;
                    else                  cnt   <= cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_mem_arbiter.sv
// Bench for zero_mem_arbiter: three instances (RAM_LAT 1, 3, 2) driven by directed vectors,
// every nonzero output cycle is matched against an expected-event queue.
module tb_zero_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] RD    = 64'hA1B2C3D4_E5F60718;
    localparam logic [31:0] RD_HI = 32'hA1B2C3D4;
    localparam logic [31:0] RD_LO = 32'hE5F60718;

    localparam logic [5:0] F_IG  = 6'b100000;
    localparam logic [5:0] F_MG  = 6'b010000;
    localparam logic [5:0] F_IV  = 6'b001000;
    localparam logic [5:0] F_MD  = 6'b000100;
    localparam logic [5:0] F_REN = 6'b000010;
    localparam logic [5:0] F_WEN = 6'b000001;

    typedef struct packed {
        logic [1:0]  dut;
        logic [15:0] cyc;
        logic [5:0]  flags;
        logic [63:0] raddr;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic [31:0] ifd;
        logic [63:0] memd;
    } ev_t;

    localparam int EW = $bits(ev_t);
    logic [EW-1:0] exp_q[$];

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic          if_req    [3];
    logic [AW-1:0] if_addr   [3];
    logic          if_gnt    [3];
    logic          if_rvalid [3];
    logic [31:0]   if_rdata  [3];
    logic          mem_req   [3];
    logic          mem_we    [3];
    logic [AW-1:0] mem_addr  [3];
    logic [DW-1:0] mem_wdata [3];
    logic [DW-1:0] mem_wmask [3];
    logic          mem_gnt   [3];
    logic          mem_done  [3];
    logic [DW-1:0] mem_rdata [3];
    logic          ram_ren   [3];
    logic          ram_wen   [3];
    logic [AW-1:0] ram_raddr [3];
    logic [AW-1:0] ram_waddr [3];
    logic [DW-1:0] ram_wdata [3];
    logic [DW-1:0] ram_wmask [3];
    logic [1:0]    fsm_state [3];
    logic [DW-1:0] ram_rdata;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        zero_mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .MEM_STREAK(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]), .mem_gnt(mem_gnt[g]),
            .mem_done(mem_done[g]), .mem_rdata(mem_rdata[g]),
            .ram_ren(ram_ren[g]), .ram_wen(ram_wen[g]), .ram_raddr(ram_raddr[g]),
            .ram_waddr(ram_waddr[g]), .ram_wdata(ram_wdata[g]), .ram_wmask(ram_wmask[g]),
            .ram_rdata(ram_rdata), .fsm_state(fsm_state[g])
        );
    end

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ev_t mk(input int d, input int c, input logic [5:0] f,
                               input logic [63:0] ra, input logic [63:0] wa,
                               input logic [63:0] wd, input logic [63:0] wm,
                               input logic [31:0] id, input logic [63:0] md);
        ev_t e;
        e.dut   = 2'(d);
        e.cyc   = 16'(c);
        e.flags = f;
        e.raddr = ra;
        e.waddr = wa;
        e.wdata = wd;
        e.wmask = wm;
        e.ifd   = id;
        e.memd  = md;
        return e;
    endfunction

    task automatic push(input ev_t e);
        exp_q.push_back(EW'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int d);
        if_req[d]    = 1'b0;
        if_addr[d]   = '0;
        mem_req[d]   = 1'b0;
        mem_we[d]    = 1'b0;
        mem_addr[d]  = '0;
        mem_wdata[d] = '0;
        mem_wmask[d] = '0;
    endtask

    task automatic check_reset_zero();
        for (int d = 0; d < 3; d++) begin
            logic [511:0] all_out;
            all_out = {if_gnt[d], if_rvalid[d], if_rdata[d], mem_gnt[d], mem_done[d], mem_rdata[d],
                       ram_ren[d], ram_wen[d], ram_raddr[d], ram_waddr[d], ram_wdata[d],
                       ram_wmask[d], fsm_state[d]};
            n_checks++;
            if (all_out == '0) n_pass++;
            else $display("FAIL reset_out dut%0d got %h required 0", d, all_out);
        end
    endtask

    task automatic if_read(input int d, input logic [63:0] a, input int lat, input logic [31:0] want);
        int t;
        step();
        t = cyc;
        if_req[d]  = 1'b1;
        if_addr[d] = a;
        push(mk(d, t, F_IG | F_REN, a, '0, '0, '0, '0, '0));
        push(mk(d, t + lat, F_IV, '0, '0, '0, '0, want, '0));
        step();
        if_req[d] = 1'b0;
        repeat (lat) step();
    endtask

    // Monitor: any cycle where a DUT drives something nonzero must match the next expected event.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            ev_t got;
            ev_t want;
            got = mk(d, cyc, {if_gnt[d], mem_gnt[d], if_rvalid[d], mem_done[d], ram_ren[d], ram_wen[d]},
                     ram_raddr[d], ram_waddr[d], ram_wdata[d], ram_wmask[d], if_rdata[d], mem_rdata[d]);
            if (got.flags != '0 || got.raddr != '0 || got.waddr != '0 || got.wdata != '0 ||
                got.wmask != '0 || got.ifd != '0 || got.memd != '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event dut%0d cyc%0d flags=%b ra=%h wa=%h if=%h md=%h",
                             d, cyc, got.flags, got.raddr, got.waddr, got.ifd, got.memd);
                end else begin
                    want = ev_t'(exp_q.pop_front());
                    if (got == want) n_pass++;
                    else $display("FAIL event got dut%0d cyc%0d f=%b ra=%h wa=%h wd=%h wm=%h if=%h md=%h required dut%0d cyc%0d f=%b ra=%h wa=%h wd=%h wm=%h if=%h md=%h",
                                  got.dut, got.cyc, got.flags, got.raddr, got.waddr, got.wdata, got.wmask, got.ifd, got.memd,
                                  want.dut, want.cyc, want.flags, want.raddr, want.waddr, want.wdata, want.wmask, want.ifd, want.memd);
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b0;
        ram_rdata = RD;
        for (int d = 0; d < 3; d++) clear_inputs(d);

        // Reset with both requests asserted: nothing may come out.
        step();
        for (int d = 0; d < 3; d++) begin
            if_req[d]   = 1'b1;
            mem_req[d]  = 1'b1;
            if_addr[d]  = 64'h80000004;
            mem_addr[d] = 64'h80000008;
        end
        #1 check_reset_zero();
        step();
        #1 check_reset_zero();
        step();
        for (int d = 0; d < 3; d++) clear_inputs(d);
        rst = 1'b1;

        // IF reads, upper and lower word.
        if_read(0, 64'h80000004, 1, RD_HI);
        if_read(0, 64'h80000008, 1, RD_LO);

        // MEM write then a read held through the write's busy cycle.
        step();
        t = cyc;
        mem_req[0]   = 1'b1;
        mem_we[0]    = 1'b1;
        mem_addr[0]  = 64'h80001000;
        mem_wdata[0] = 64'hDEADBEEF;
        mem_wmask[0] = 64'hFFFFFFFF;
        push(mk(0, t, F_MG | F_WEN, '0, 64'h80001000, 64'hDEADBEEF, 64'hFFFFFFFF, '0, '0));
        push(mk(0, t + 1, F_MD, '0, '0, '0, '0, '0, '0));
        step();
        mem_we[0]    = 1'b0;
        mem_addr[0]  = 64'h80002000;
        mem_wdata[0] = '0;
        mem_wmask[0] = '0;
        push(mk(0, t + 2, F_MG | F_REN, 64'h80002000, '0, '0, '0, '0, '0));
        push(mk(0, t + 3, F_MD, '0, '0, '0, '0, '0, RD));
        step();
        step();
        mem_req[0] = 1'b0;
        step();

        // Both requesting continuously: M,M,M,M,I,M,M,M,M,I.
        step();
        t = cyc;
        if_req[0]   = 1'b1;
        if_addr[0]  = 64'h80000010;
        mem_req[0]  = 1'b1;
        mem_addr[0] = 64'h80003000;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push(mk(0, t + 2 * k, F_IG | F_REN, 64'h80000010, '0, '0, '0, '0, '0));
                push(mk(0, t + 2 * k + 1, F_IV, '0, '0, '0, '0, RD_LO, '0));
            end else begin
                push(mk(0, t + 2 * k, F_MG | F_REN, 64'h80003000, '0, '0, '0, '0, '0));
                push(mk(0, t + 2 * k + 1, F_MD, '0, '0, '0, '0, '0, RD));
            end
        end
        repeat (19) step();
        if_req[0]  = 1'b0;
        mem_req[0] = 1'b0;
        step();

        // if_req dropped after the first M grant clears the streak; re-raised it waits 4 more M grants.
        step();
        t = cyc;
        if_req[0]  = 1'b1;
        mem_req[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            push(mk(0, t + 2 * k, F_MG | F_REN, 64'h80003000, '0, '0, '0, '0, '0));
            push(mk(0, t + 2 * k + 1, F_MD, '0, '0, '0, '0, '0, RD));
        end
        push(mk(0, t + 14, F_IG | F_REN, 64'h80000010, '0, '0, '0, '0, '0));
        push(mk(0, t + 15, F_IV, '0, '0, '0, '0, RD_LO, '0));
        step();
        if_req[0] = 1'b0;
        repeat (4) step();
        if_req[0] = 1'b1;
        repeat (10) step();
        if_req[0]  = 1'b0;
        mem_req[0] = 1'b0;
        step();

        // RAM_LAT=3: reset while a MEM read is outstanding, then a fresh fetch.
        step();
        t = cyc;
        mem_req[1]  = 1'b1;
        mem_addr[1] = 64'h80004000;
        push(mk(1, t, F_MG | F_REN, 64'h80004000, '0, '0, '0, '0, '0));
        step();
        rst = 1'b0;
        mem_req[1] = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (fsm_state[1] == 2'd0) n_pass++;
        else $display("FAIL state_after_reset got %0d required 0", fsm_state[1]);
        step();
        if_req[1]  = 1'b1;
        if_addr[1] = 64'h80000004;
        push(mk(1, t + 4, F_IG | F_REN, 64'h80000004, '0, '0, '0, '0, '0));
        push(mk(1, t + 7, F_IV, '0, '0, '0, '0, RD_HI, '0));
        step();
        if_req[1] = 1'b0;
        repeat (3) step();

        // RAM_LAT=2: if_req held, address changes between grants must not leak into earlier accesses.
        step();
        t = cyc;
        if_req[2]  = 1'b1;
        if_addr[2] = 64'h80000020;
        push(mk(2, t, F_IG | F_REN, 64'h80000020, '0, '0, '0, '0, '0));
        push(mk(2, t + 2, F_IV, '0, '0, '0, '0, RD_LO, '0));
        push(mk(2, t + 3, F_IG | F_REN, 64'h80000024, '0, '0, '0, '0, '0));
        push(mk(2, t + 5, F_IV, '0, '0, '0, '0, RD_HI, '0));
        push(mk(2, t + 6, F_IG | F_REN, 64'h80000028, '0, '0, '0, '0, '0));
        push(mk(2, t + 8, F_IV, '0, '0, '0, '0, RD_LO, '0));
        step();
        if_addr[2] = 64'h80000024;
        repeat (3) step();
        if_addr[2] = 64'h80000028;
        repeat (4) step();
        if_req[2] = 1'b0;
        step();

        // RAM_LAT=2 write still completes one cycle after the grant.
        step();
        t = cyc;
        mem_req[2]   = 1'b1;
        mem_we[2]    = 1'b1;
        mem_addr[2]  = 64'h80005000;
        mem_wdata[2] = 64'h0123456789ABCDEF;
        mem_wmask[2] = 64'hFFFF0000FFFF0000;
        push(mk(2, t, F_MG | F_WEN, '0, 64'h80005000, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, '0, '0));
        push(mk(2, t + 1, F_MD, '0, '0, '0, '0, '0, '0));
        step();
        mem_req[2] = 1'b0;
        mem_we[2]  = 1'b0;
        step();

        repeat (3) step();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover_events got %0d pending required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
